cache_nway_wb: RTL and testbench
================================

Name: cache_nway_wb

Overview:
- Clocked, parametrised N-way set-associative write-back, write-allocate data cache with true-LRU replacement.
- Sits between the single-cycle CPU datapath and the block-wide main memory.
- Generalises the existing fixed 2-set/2-way combinational cache in four ways: configurable geometry, a ready/ack handshake on both sides, registered state, and synchronous reset.

Parameters:
- ADDR_W, 10: byte-address width.
- DATA_W, 32: CPU word width.
- WORDS, 4: words per block, power of 2; BLOCK_W = WORDS*DATA_W.
- SETS, 2: number of sets, power of 2, ≥2.
- WAYS, 2: associativity, power of 2, ≥2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  request valid; sampled only in IDLE.
- cpu_we  in  1  0 = read, 1 = write.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  hit/miss of the completing request; valid with cpu_ready.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write-back, 0 = refill.
- mem_addr  out  ADDR_W  block-aligned address (offset bits = 0).
- mem_wdata  out  BLOCK_W  victim block.
- mem_rdata  in  BLOCK_W  refill block; valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- Address split: offset = log2(WORDS*4) LSBs, then index = log2(SETS) bits, then tag = remaining MSBs. Word select = offset[msb:2].
- Line storage: valid, dirty, tag, data, plus a log2(WAYS)-bit age per way.
- Request capture: in IDLE with cpu_req = 1, addr, we and wdata are latched. CPU inputs are don't-care afterwards.

FSM states: IDLE, LOOKUP, WBACK, REFILL, RESP.
- IDLE -> LOOKUP on cpu_req.
- LOOKUP, hit:
  - read: rdata = word.
  - write: merge word, set dirty = 1.
  - Go to RESP. Latency: request-to-cpu_ready = 2 cycles.
- LOOKUP, miss: select victim.
  - Victim = lowest-index invalid way; if none, the way with maximum age.
  - Victim valid and dirty -> WBACK; otherwise -> REFILL.
- WBACK:
  - mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 0}, mem_wdata = victim data.
  - On mem_ack: clear dirty, -> REFILL.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = {req tag, index, 0}.
  - On mem_ack: write mem_rdata, set tag, valid = 1, dirty = 0.
  - For a write request, merge cpu word and set dirty = 1.
  - -> RESP.
- RESP:
  - cpu_ready = 1 for exactly one cycle; cpu_hit = lookup result; cpu_rdata = requested word.
  - -> IDLE. A cpu_req in this cycle is ignored.

LRU:
- On every completed access, the accessed way's age goes to 0.
- Ways with age less than its old age increment by 1; others are unchanged.
- Ages are always a permutation of 0..WAYS-1.

Memory handshake:
- mem_req, mem_we, mem_addr and mem_wdata are stable while waiting.
- mem_ack is ignored when mem_req = 0.
- mem_ack in the same cycle as mem_req rise is legal: one-cycle memory.
- mem_req drops the cycle after mem_ack.

Reset:
- All valid and dirty bits = 0; age of way w = w; state = IDLE.
- cpu_ready = 0, cpu_hit = 0, cpu_rdata = 0; mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Reset mid-WBACK/REFILL aborts: mem_req falls the next cycle. The in-flight request is dropped with no cpu_ready, and dirty data is discarded.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Each increments on the cpu_ready cycle according to cpu_hit and saturates at 0xFFFFFFFF.
  - Both are cleared by reset.
- CACHE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package cache_pkg: FSM state enum; localparams OFF_W, IDX_W, TAG_W, BLOCK_W, AGE_W; line-metadata struct {valid, dirty, tag}.
- One sub-module, cache_lru: per-set age array with touch(set, way) and victim(set) outputs, parametrised by SETS and WAYS.

Test Plan:
All scenarios use defaults WAYS=2, SETS=2, WORDS=4: index = addr[4], tag = addr[9:5]. Memory returns mem_ack 3 cycles after mem_req.
1. After reset, read 0x004 -> mem_req, mem_we=0, mem_addr=0x000. On ack with block {0x33,0x22,0x11,0x00}: cpu_rdata = 0x11, cpu_hit = 0. Read 0x00C -> cpu_hit = 1, cpu_rdata = 0x33, cpu_ready 2 cycles after cpu_req.
2. Write 0x028 data 0xDEADBEEF (miss) -> refill 0x020, line dirty. Read 0x028 -> hit, 0xDEADBEEF, no mem_req.
3. Read 0x000, read 0x020, read 0x000, read 0x040 -> the 0x020 line is evicted (LRU). Re-read 0x000 -> hit; read 0x020 -> miss.
4. Dirty eviction: write 0x000 = 0xA5A5A5A5, read 0x020, read 0x040 -> WBACK with mem_we=1, mem_addr=0x000, mem_wdata[31:0] = 0xA5A5A5A5. Then REFILL with mem_addr=0x040.
5. Assert reset during REFILL -> next cycle mem_req = 0, no cpu_ready. Re-read the same address -> miss.
6. With CACHE_STATS_EN defined, run scenario 1 -> hit_count = 1, miss_count = 1.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared types and default geometry for the N-way write-back cache.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int WORDS_DEF  = 4;
    localparam int SETS_DEF   = 2;
    localparam int WAYS_DEF   = 2;

    localparam int OFF_W   = $clog2(WORDS_DEF * 4);
    localparam int IDX_W   = $clog2(SETS_DEF);
    localparam int TAG_W   = ADDR_W_DEF - OFF_W - IDX_W;
    localparam int BLOCK_W = WORDS_DEF * DATA_W_DEF;
    localparam int AGE_W   = $clog2(WAYS_DEF);

    // Tag field sized for the widest supported tag; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WBACK  = 3'd2,
        S_REFILL = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } line_meta_t;

endpackage
`default_nettype wire

// File: rtl/cache_lru.sv
`default_nettype none
// ============================================================================
// Module   : cache_lru
// Purpose  : Per-set true-LRU age array; age 0 = most recent, WAYS-1 = victim.
// Revision : 1.0 - initial release
// ============================================================================
module cache_lru #(
    parameter int SETS = 2,
    parameter int WAYS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      touch_en,
    input  logic [$clog2(SETS)-1:0]   touch_set,
    input  logic [$clog2(WAYS)-1:0]   touch_way,
    input  logic [$clog2(SETS)-1:0]   query_set,
    output logic [$clog2(WAYS)-1:0]   victim_way
);
    import cache_pkg::*;

    localparam int c_age_w = $clog2(WAYS);

    logic [c_age_w-1:0] r_age [SETS][WAYS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= c_age_w'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (c_age_w'(w) == touch_way) begin
                    r_age[touch_set][w] <= '0;
                end else if (r_age[touch_set][w] < r_age[touch_set][touch_way]) begin
                    r_age[touch_set][w] <= r_age[touch_set][w] + 1'b1;
                end
            end
        end
    end

    // Ages stay a permutation, so exactly one way holds the maximum.
    always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_age[query_set][w] == c_age_w'(WAYS - 1)) begin
                victim_way = c_age_w'(w);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_nway_wb.sv
`default_nettype none
// ============================================================================
// Module   : cache_nway_wb
// Purpose  : N-way set-associative write-back/write-allocate cache, true LRU.
//            Define CACHE_STATS_EN to add saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_nway_wb #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 2,
    parameter int WAYS   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_ready,
    output logic                      cpu_hit,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WORDS*DATA_W-1:0]   mem_wdata,
    input  logic [WORDS*DATA_W-1:0]   mem_rdata,
    input  logic                      mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
`endif
);
    import cache_pkg::*;

    localparam int c_off_w   = $clog2(WORDS * 4);
    localparam int c_idx_w   = $clog2(SETS);
    localparam int c_tag_w   = ADDR_W - c_off_w - c_idx_w;
    localparam int c_block_w = WORDS * DATA_W;
    localparam int c_age_w   = $clog2(WAYS);
    localparam int c_wsel_w  = $clog2(WORDS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:2]    r_waddr;
    logic                 r_we;
    logic [DATA_W-1:0]    r_wdata;
    logic [c_age_w-1:0]   r_victim;
    line_meta_t           r_meta [SETS][WAYS];
    logic [c_block_w-1:0] r_data [SETS][WAYS];
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_hit;

    logic [c_idx_w-1:0]   w_idx;
    logic [c_tag_w-1:0]   w_tag;
    logic [c_wsel_w-1:0]  w_word;
    logic                 w_hit;
    logic [c_age_w-1:0]   w_hit_way;
    logic                 w_inv_found;
    logic [c_age_w-1:0]   w_inv_way;
    logic [c_age_w-1:0]   w_lru_victim;
    logic [c_age_w-1:0]   w_victim;
    logic [c_block_w-1:0] w_hit_block;
    logic [DATA_W-1:0]    w_hit_word;
    logic [c_block_w-1:0] w_refill_block;
    logic                 w_touch_en;
    logic [c_age_w-1:0]   w_touch_way;
    logic                 w_unused;

    assign w_idx    = r_waddr[c_off_w +: c_idx_w];
    assign w_tag    = r_waddr[ADDR_W-1 -: c_tag_w];
    assign w_word   = r_waddr[c_off_w-1:2];
    assign w_unused = ^cpu_addr[1:0];

    // Invalid ways scanned high-to-low so the lowest index wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_meta[w_idx][w].valid && (r_meta[w_idx][w].tag == TAG_MAX_W'(w_tag))) begin
                w_hit     = 1'b1;
                w_hit_way = c_age_w'(w);
            end
            if (!r_meta[w_idx][w].valid) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_age_w'(w);
            end
        end
    end

    assign w_victim    = w_inv_found ? w_inv_way : w_lru_victim;
    assign w_hit_block = r_data[w_idx][w_hit_way];
    assign w_hit_word  = r_we ? r_wdata : w_hit_block[w_word*DATA_W +: DATA_W];

    always_comb begin
        w_refill_block = mem_rdata;
        if (r_we) begin
            w_refill_block[w_word*DATA_W +: DATA_W] = r_wdata;
        end
    end

    assign w_touch_en  = ((r_state == S_LOOKUP) && w_hit) || ((r_state == S_REFILL) && mem_ack);
    assign w_touch_way = (r_state == S_LOOKUP) ? w_hit_way : r_victim;

    cache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk        (clk),
        .reset      (reset),
        .touch_en   (w_touch_en),
        .touch_set  (w_idx),
        .touch_way  (w_touch_way),
        .query_set  (w_idx),
        .victim_way (w_lru_victim)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cpu_ready   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_state_nxt = S_RESP;
                end else if (r_meta[w_idx][w_victim].valid && r_meta[w_idx][w_victim].dirty) begin
                    w_state_nxt = S_WBACK;
                end else begin
                    w_state_nxt = S_REFILL;
                end
            end
            S_WBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_meta[w_idx][r_victim].tag[c_tag_w-1:0], w_idx, {c_off_w{1'b0}}};
                mem_wdata = r_data[w_idx][r_victim];
                if (mem_ack) begin
                    w_state_nxt = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, {c_off_w{1'b0}}};
                if (mem_ack) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                cpu_ready   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_meta[s][w] <= '0;
                end
            end
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else begin
            case (r_state)
                S_LOOKUP: begin
                    r_hit <= w_hit;
                    if (w_hit) begin
                        r_rdata <= w_hit_word;
                        if (r_we) begin
                            r_meta[w_idx][w_hit_way].dirty <= 1'b1;
                        end
                    end
                end
                S_WBACK: begin
                    if (mem_ack) begin
                        r_meta[w_idx][r_victim].dirty <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        r_meta[w_idx][r_victim] <= '{valid: 1'b1, dirty: r_we, tag: TAG_MAX_W'(w_tag)};
                        r_rdata <= w_refill_block[w_word*DATA_W +: DATA_W];
                    end
                end
                default: ;
            endcase
        end
    end

    // Request capture and line data need no reset; validity gates their use.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && cpu_req) begin
            r_waddr <= cpu_addr[ADDR_W-1:2];
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
        end
        if (r_state == S_LOOKUP) begin
            r_victim <= w_victim;
            if (w_hit && r_we) begin
                r_data[w_idx][w_hit_way][w_word*DATA_W +: DATA_W] <= r_wdata;
            end
        end
        if ((r_state == S_REFILL) && mem_ack) begin
            r_data[w_idx][r_victim] <= w_refill_block;
        end
    end

    assign cpu_rdata = r_rdata;
    assign cpu_hit   = r_hit;

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == S_RESP) begin
            if (r_hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_nway_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_nway_wb
// Purpose  : Directed self-checking bench for cache_nway_wb (default geometry).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_nway_wb;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [9:0]   cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_hit;
    logic         mem_req;
    logic         mem_we;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] mem [64];
    int           ack_cnt = 0;
    int           req_cycles = 0;
    int           log_n = 0;
    logic         log_we [32];
    logic [9:0]   log_addr [32];
    logic [127:0] log_wd [32];

    cache_nway_wb dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .cpu_hit    (cpu_hit),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory responder: acks three cycles after mem_req, logs each transfer.
    always @(negedge clk) begin
        if (mem_req) req_cycles++;
        if (reset) begin
            ack_cnt = 0;
            mem_ack = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end else if (mem_req) begin
            ack_cnt++;
            if (ack_cnt == 3) begin
                mem_ack = 1'b1;
                if (log_n < 32) begin
                    log_we[log_n]   = mem_we;
                    log_addr[log_n] = mem_addr;
                    log_wd[log_n]   = mem_wdata;
                    log_n++;
                end
                if (mem_we) mem[mem_addr[9:4]] = mem_wdata;
                else        mem_rdata = mem[mem_addr[9:4]];
            end
        end else begin
            ack_cnt = 0;
        end
    end

    function automatic logic [31:0] pat(input int b, input int i);
        return 32'h1000_0000 + 32'(b * 256 + i);
    endfunction

    task automatic access(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic hit, output int lat);
        logic got;
        got = 1'b0;
        rd  = '0;
        hit = 1'b0;
        lat = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = ~we; cpu_addr = 10'h3FF; cpu_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_ready) begin
                got = 1'b1;
                rd  = cpu_rdata;
                hit = cpu_hit;
            end
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL access_timeout addr=%h got no cpu_ready want ready within 60 cycles", addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (cpu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", cpu_ready); end
        vectors++; if (cpu_hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit got %b want 0", cpu_hit); end
        vectors++; if (cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
        vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b/%b want 0/0", mem_req, mem_we); end
        vectors++; if (mem_addr !== 10'h0 || mem_wdata !== 128'h0) begin miscompares++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_miss_then_hit();
        logic [31:0] rd; logic hit; int lat; int l0;
        l0 = log_n;
        access(1'b0, 10'h004, 32'h0, rd, hit, lat);
        vectors++; if (log_n !== l0 + 1 || log_we[l0] !== 1'b0 || log_addr[l0] !== 10'h000) begin
            miscompares++; $display("FAIL refill_req got n=%0d we=%b addr=%h want n=%0d we=0 addr=000", log_n, log_we[l0], log_addr[l0], l0 + 1); end
        vectors++; if (rd !== 32'h11 || hit !== 1'b0) begin miscompares++; $display("FAIL miss_read got %h hit=%b want 00000011 hit=0", rd, hit); end
        access(1'b0, 10'h00C, 32'h0, rd, hit, lat);
        vectors++; if (rd !== 32'h33 || hit !== 1'b1) begin miscompares++; $display("FAIL hit_read got %h hit=%b want 00000033 hit=1", rd, hit); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL hit_latency got %0d want 2", lat); end
        @(negedge clk);
        vectors++; if (cpu_ready !== 1'b0) begin miscompares++; $display("FAIL ready_pulse got %b want 0", cpu_ready); end
    endtask

    task automatic test_write_allocate();
        logic [31:0] rd; logic hit; int lat; int l0; int rc;
        l0 = log_n;
        access(1'b1, 10'h028, 32'hDEAD_BEEF, rd, hit, lat);
        vectors++; if (hit !== 1'b0 || log_n !== l0 + 1 || log_we[l0] !== 1'b0 || log_addr[l0] !== 10'h020) begin
            miscompares++; $display("FAIL write_miss got hit=%b n=%0d addr=%h want hit=0 n=%0d addr=020", hit, log_n, log_addr[l0], l0 + 1); end
        rc = req_cycles;
        access(1'b0, 10'h028, 32'h0, rd, hit, lat);
        vectors++; if (rd !== 32'hDEAD_BEEF || hit !== 1'b1) begin miscompares++; $display("FAIL write_readback got %h hit=%b want deadbeef hit=1", rd, hit); end
        vectors++; if (req_cycles !== rc) begin miscompares++; $display("FAIL hit_no_mem got %0d req cycles want 0", req_cycles - rc); end
    endtask

    task automatic test_lru();
        logic [31:0] rd; logic hit; int lat; int l0;
        access(1'b0, 10'h000, 32'h0, rd, hit, lat);
        access(1'b0, 10'h020, 32'h0, rd, hit, lat);
        access(1'b0, 10'h000, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL lru_warm got %h hit=%b want 00000000 hit=1", rd, hit); end
        l0 = log_n;
        access(1'b0, 10'h040, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b0 || rd !== pat(4, 0)) begin miscompares++; $display("FAIL lru_fill got %h hit=%b want %h hit=0", rd, hit, pat(4, 0)); end
        vectors++; if (log_n !== l0 + 2 || log_we[l0] !== 1'b1 || log_addr[l0] !== 10'h020 || log_wd[l0][95:64] !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL lru_wback got n=%0d we=%b addr=%h w2=%h want n=%0d we=1 addr=020 w2=deadbeef", log_n, log_we[l0], log_addr[l0], log_wd[l0][95:64], l0 + 2); end
        vectors++; if (log_we[l0+1] !== 1'b0 || log_addr[l0+1] !== 10'h040) begin miscompares++; $display("FAIL lru_refill got we=%b addr=%h want 0/040", log_we[l0+1], log_addr[l0+1]); end
        access(1'b0, 10'h000, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL lru_keep got hit=%b want 1", hit); end
        access(1'b0, 10'h020, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b0 || rd !== pat(2, 0)) begin miscompares++; $display("FAIL lru_evicted got %h hit=%b want %h hit=0", rd, hit, pat(2, 0)); end
        access(1'b0, 10'h028, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b1 || rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wback_data got %h hit=%b want deadbeef hit=1", rd, hit); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] rd; logic hit; int lat; int l0;
        access(1'b1, 10'h000, 32'hA5A5_A5A5, rd, hit, lat);
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL write_hit got hit=%b want 1", hit); end
        access(1'b0, 10'h020, 32'h0, rd, hit, lat);
        l0 = log_n;
        access(1'b0, 10'h040, 32'h0, rd, hit, lat);
        vectors++; if (log_n !== l0 + 2 || log_we[l0] !== 1'b1 || log_addr[l0] !== 10'h000 || log_wd[l0][31:0] !== 32'hA5A5_A5A5) begin
            miscompares++; $display("FAIL dirty_wback got n=%0d we=%b addr=%h w0=%h want n=%0d we=1 addr=000 w0=a5a5a5a5", log_n, log_we[l0], log_addr[l0], log_wd[l0][31:0], l0 + 2); end
        vectors++; if (log_we[l0+1] !== 1'b0 || log_addr[l0+1] !== 10'h040 || hit !== 1'b0 || rd !== pat(4, 0)) begin
            miscompares++; $display("FAIL dirty_refill got we=%b addr=%h rd=%h hit=%b want 0/040/%h/0", log_we[l0+1], log_addr[l0+1], rd, hit, pat(4, 0)); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic hit; int lat; logic seen; logic saw_ready;
        seen = 1'b0;
        saw_ready = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h060;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we) seen = 1'b1;
        end
        vectors++; if (!seen || mem_addr !== 10'h060) begin miscompares++; $display("FAIL abort_refill got seen=%b addr=%h want 1/060", seen, mem_addr); end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin miscompares++; $display("FAIL abort_drop got req=%b ready=%b want 0/0", mem_req, cpu_ready); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_ready) saw_ready = 1'b1;
        end
        vectors++; if (saw_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b want 0", saw_ready); end
        access(1'b0, 10'h060, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b0 || rd !== pat(6, 0)) begin miscompares++; $display("FAIL abort_reread got %h hit=%b want %h hit=0", rd, hit, pat(6, 0)); end
        access(1'b0, 10'h000, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b0 || rd !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL post_reset_read got %h hit=%b want a5a5a5a5 hit=0", rd, hit); end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] rd; logic hit; int lat;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vectors++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin miscompares++; $display("FAIL stats_reset got %0d/%0d want 0/0", hit_count, miss_count); end
        access(1'b0, 10'h004, 32'h0, rd, hit, lat);
        access(1'b0, 10'h00C, 32'h0, rd, hit, lat);
        @(negedge clk);
        vectors++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin miscompares++; $display("FAIL stats_count got %0d/%0d want 1/1", hit_count, miss_count); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int b = 0; b < 64; b++) begin
            for (int i = 0; i < 4; i++) begin
                mem[b][i*32 +: 32] = pat(b, i);
            end
        end
        mem[0] = {32'h33, 32'h22, 32'h11, 32'h00};
        test_reset();
        test_miss_then_hit();
        test_write_allocate();
        test_lru();
        test_dirty_evict();
        test_reset_abort();
`ifdef CACHE_STATS_EN
        mem[0] = {32'h33, 32'h22, 32'h11, 32'h00};
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
